// File: rtl/sev_seg_scan_capture_if.sv
// Signal bundle between a 4-digit multiplexed seven-segment driver and its capture monitor.
// The master side drives the display lines; the slave side is the monitor.
interface sev_seg_scan_capture_if;
  logic [3:0] an_n;
  logic [7:1] seg_n;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic [3:0] digit_3;
  logic [3:0] digit_4;
  logic [3:0] digit_valid;
  logic [3:0] bad_pattern;
  logic       anode_error;
  logic       order_error;
  logic       frame_done;

  modport master (
    output an_n, seg_n,
    input  digit_1, digit_2, digit_3, digit_4, digit_valid, bad_pattern,
    input  anode_error, order_error, frame_done
  );

  modport slave (
    input  an_n, seg_n,
    output digit_1, digit_2, digit_3, digit_4, digit_valid, bad_pattern,
    output anode_error, order_error, frame_done
  );
endinterface

// File: rtl/sev_seg_scan_capture.sv
// Passive seven-segment scan monitor: waits for each dwell to settle, decodes the
// segment pattern back to a nibble per digit and tracks the 1-2-3-4 scan order.
module sev_seg_scan_capture #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  sev_seg_scan_capture_if.slave bus
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic {HUNT, SCAN} state_t;

  logic [3:0] an_r;
  logic [7:1] seg_r;
  logic [3:0] cnt;
  logic       captured;
  state_t     state, state_nx;
  logic [1:0] exp_idx, exp_nx;
  logic [3:0] digit_q [4];
  logic [3:0] valid_q, bad_q, bad_nx;
  logic       anode_q, order_q, frame_q;
  logic       order_nx, frame_nx;

  logic       single, blank, strobe, cap, multi;
  logic [1:0] idx;
  logic [4:0] dec;

  // Returns {in_table, nibble}
  function automatic logic [4:0] decode(input logic [7:1] s);
    case (s)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    single = 1'b1;
    idx    = 2'd0;
    case (an_r)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      4'b1110: idx = 2'd3;
      default: single = 1'b0;
    endcase
    blank  = (an_r == 4'b1111);
    // captured gates both digit captures and anode errors to once per dwell
    strobe = (cnt == SETTLE) && !captured && !blank;
    cap    = strobe && single;
    multi  = strobe && !single;
    dec    = decode(seg_r);
    bad_nx = bad_q;
    if (cap) bad_nx[idx] = !dec[4];
  end

  always_comb begin
    state_nx = state;
    exp_nx   = exp_idx;
    order_nx = 1'b0;
    frame_nx = 1'b0;
    if (multi) begin
      state_nx = HUNT;
      exp_nx   = 2'd0;
    end else if (cap) begin
      if (state == HUNT) begin
        if (idx == 2'd0) begin
          state_nx = SCAN;
          exp_nx   = 2'd1;
        end
      end else if (idx == exp_idx) begin
        if (idx == 2'd3) begin
          frame_nx = ~|bad_nx;
          state_nx = HUNT;
          exp_nx   = 2'd0;
        end else begin
          exp_nx = 2'(exp_idx + 2'd1);
        end
      end else begin
        order_nx = 1'b1;
        if (idx == 2'd0) begin
          state_nx = SCAN;
          exp_nx   = 2'd1;
        end else begin
          state_nx = HUNT;
          exp_nx   = 2'd0;
        end
      end
    end
  end

  // Input sample and settle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r     <= 4'b1111;
      seg_r    <= 7'b1111111;
      cnt      <= 4'd0;
      captured <= 1'b0;
    end else begin
      an_r  <= bus.an_n;
      seg_r <= bus.seg_n;
      if ({bus.an_n, bus.seg_n} != {an_r, seg_r}) begin
        cnt      <= 4'd1;
        captured <= 1'b0;
      end else begin
        if (cnt < SETTLE) cnt <= cnt + 4'd1;
        if (strobe) captured <= 1'b1;
      end
    end
  end

  // Capture registers and order FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= HUNT;
      exp_idx <= 2'd0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
      valid_q <= 4'd0;
      bad_q   <= 4'd0;
      anode_q <= 1'b0;
      order_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state   <= state_nx;
      exp_idx <= exp_nx;
      bad_q   <= bad_nx;
      anode_q <= multi;
      order_q <= order_nx;
      frame_q <= frame_nx;
      if (cap) begin
        valid_q[idx] <= dec[4];
        if (dec[4]) digit_q[idx] <= dec[3:0];
      end
    end
  end

  assign bus.digit_1     = digit_q[0];
  assign bus.digit_2     = digit_q[1];
  assign bus.digit_3     = digit_q[2];
  assign bus.digit_4     = digit_q[3];
  assign bus.digit_valid = valid_q;
  assign bus.bad_pattern = bad_q;
  assign bus.anode_error = anode_q;
  assign bus.order_error = order_q;
  assign bus.frame_done  = frame_q;

endmodule

// File: tb/tb_sev_seg_scan_capture.sv
// Directed, table-driven bench for the seven-segment scan monitor (SETTLE_CYCLES = 2).
module tb_sev_seg_scan_capture;

  typedef struct {
    logic [3:0]  an;
    logic [7:1]  seg;
    int          hold;
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  b;
    int          ae;
    int          oe;
    int          fd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:1] seg_tbl [16];
  localparam logic [7:1] BADP = 7'b1111110;
  localparam logic [7:1] BLK  = 7'b1111111;

  vec_t vt [38];

  sev_seg_scan_capture_if bus ();

  sev_seg_scan_capture #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] an, input logic [7:1] seg, input int hold,
                         input logic [15:0] d, input logic [3:0] v, input logic [3:0] b,
                         input int ae, input int oe, input int fd);
    vt[i].an = an; vt[i].seg = seg; vt[i].hold = hold; vt[i].d = d;
    vt[i].v = v; vt[i].b = b; vt[i].ae = ae; vt[i].oe = oe; vt[i].fd = fd;
  endtask

  function automatic logic [15:0] digits();
    return {bus.digit_1, bus.digit_2, bus.digit_3, bus.digit_4};
  endfunction

  function automatic logic [26:0] all_out();
    return {digits(), bus.digit_valid, bus.bad_pattern,
            bus.anode_error, bus.order_error, bus.frame_done};
  endfunction

  // Drives one dwell starting just after an edge and tallies pulses over its edges.
  task automatic apply_vec(input int i);
    int ae, oe, fd;
    ae = 0; oe = 0; fd = 0;
    bus.an_n  = vt[i].an;
    bus.seg_n = vt[i].seg;
    repeat (vt[i].hold) begin
      @(posedge clk); #1;
      ae += int'(bus.anode_error);
      oe += int'(bus.order_error);
      fd += int'(bus.frame_done);
    end
    check($sformatf("vec%0d digits", i), 32'(digits()), 32'(vt[i].d));
    check($sformatf("vec%0d valid", i), 32'(bus.digit_valid), 32'(vt[i].v));
    check($sformatf("vec%0d bad", i), 32'(bus.bad_pattern), 32'(vt[i].b));
    check($sformatf("vec%0d anode_err", i), 32'(ae), 32'(vt[i].ae));
    check($sformatf("vec%0d order_err", i), 32'(oe), 32'(vt[i].oe));
    check($sformatf("vec%0d frame_done", i), 32'(fd), 32'(vt[i].fd));
  endtask

  initial begin
    seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111; seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
    seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100; seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100; seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
    seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010; seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;

    // multi-enable dwell first so the sweep starts from HUNT
    set_vec(0, 4'b0011, seg_tbl[8], 4, 16'h3000, 4'b0001, 4'b0000, 1, 0, 0);
    for (int i = 0; i < 16; i++)
      set_vec(1 + i, 4'b1011, seg_tbl[i], 4, {4'h3, 4'(i), 8'h00}, 4'b0011, 4'b0000, 0, 0, 0);
    set_vec(17, 4'b0111, seg_tbl[1], 8, 16'h1F00, 4'b0011, 4'b0000, 0, 0, 0);
    set_vec(18, 4'b1011, seg_tbl[2], 8, 16'h1200, 4'b0011, 4'b0000, 0, 0, 0);
    set_vec(19, 4'b1101, seg_tbl[3], 8, 16'h1230, 4'b0111, 4'b0000, 0, 0, 0);
    set_vec(20, 4'b0111, seg_tbl[1], 8, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(21, 4'b1011, seg_tbl[2], 8, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(22, 4'b1101, seg_tbl[3], 8, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(23, 4'b1110, seg_tbl[4], 8, 16'h1234, 4'b1111, 4'b0000, 0, 0, 1);
    set_vec(24, 4'b1111, BLK,        4, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(25, 4'b1011, seg_tbl[7], 1, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(26, 4'b1111, BLK,        4, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(27, 4'b1101, BADP,       4, 16'h1234, 4'b1011, 4'b0100, 0, 0, 0);
    set_vec(28, 4'b0111, seg_tbl[5], 4, 16'h5234, 4'b1011, 4'b0100, 0, 0, 0);
    set_vec(29, 4'b1101, seg_tbl[6], 4, 16'h5264, 4'b1111, 4'b0000, 0, 1, 0);
    set_vec(30, 4'b0111, seg_tbl[1], 4, 16'h1264, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(31, 4'b1011, seg_tbl[2], 4, 16'h1264, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(32, 4'b1101, seg_tbl[3], 4, 16'h1234, 4'b1111, 4'b0000, 0, 0, 0);
    set_vec(33, 4'b1110, BADP,       4, 16'h1234, 4'b0111, 4'b1000, 0, 0, 0);
    set_vec(34, 4'b0111, seg_tbl[9], 4, 16'h9234, 4'b0111, 4'b1000, 0, 0, 0);
    set_vec(35, 4'b1011, seg_tbl[10],4, 16'h9A34, 4'b0111, 4'b1000, 0, 0, 0);
    set_vec(36, 4'b1101, seg_tbl[3], 4, 16'h0030, 4'b0100, 4'b0000, 0, 0, 0);
    set_vec(37, 4'b1110, seg_tbl[4], 4, 16'h0034, 4'b1100, 4'b0000, 0, 0, 0);

    // Reset held while the display lines toggle
    bus.an_n  = 4'b0111;
    bus.seg_n = seg_tbl[3];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_hold%0d", i), 32'(all_out()), 32'd0);
      bus.an_n  = 4'($urandom_range(0, 15));
      bus.seg_n = 7'($urandom_range(0, 127));
    end
    bus.an_n  = 4'b0111;
    bus.seg_n = seg_tbl[3];
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_e0 valid", 32'(bus.digit_valid), 32'd0);
    @(posedge clk); #1;
    check("post_reset_e1 valid", 32'(bus.digit_valid), 32'd0);
    @(posedge clk); #1;
    check("post_reset_e2 digit_1", 32'(bus.digit_1), 32'd3);
    check("post_reset_e2 valid", 32'(bus.digit_valid), 32'b0001);

    for (int i = 0; i <= 19; i++) apply_vec(i);

    // First frame completion: frame_done must land with the digit_4 update
    bus.an_n  = 4'b1110;
    bus.seg_n = seg_tbl[4];
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("frame_early pulse", 32'(bus.frame_done), 32'd0);
    check("frame_early digit_4", 32'(bus.digit_4), 32'd0);
    @(posedge clk); #1;
    check("frame_edge pulse", 32'(bus.frame_done), 32'd1);
    check("frame_edge digit_4", 32'(bus.digit_4), 32'd4);
    check("frame_edge valid", 32'(bus.digit_valid), 32'b1111);
    repeat (5) begin
      @(posedge clk); #1;
      check("frame_after pulse", 32'(bus.frame_done), 32'd0);
    end

    for (int i = 20; i <= 35; i++) apply_vec(i);

    // Reset in the middle of a dwell partway through a frame
    bus.an_n  = 4'b1101;
    bus.seg_n = seg_tbl[3];
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_reset outputs", 32'(all_out()), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_reset held", 32'(all_out()), 32'd0);
    reset = 1'b0;

    for (int i = 36; i <= 37; i++) apply_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_capture.md
Name: sev_seg_scan_capture

Overview:
Passive monitor for the 4-digit multiplexed seven-segment display interface. It samples the active-low digit enables and segment lines, waits for each dwell to settle, and decodes the segment pattern back to a hex nibble per digit. It also checks scan order and flags malformed enables and patterns. It is used on-chip and in benches to confirm what the display driver is actually showing, for example stopwatch digits.

Parameters:
SETTLE_CYCLES, 2, consecutive identical samples of an_n and seg_n required before capture (legal range 1..15)

Ports:
clk  input  1  system clock; all inputs are synchronous to it
reset  input  1  asynchronous, active-high
an_n  input  4  digit enables, active-low: 0111=digit 1, 1011=digit 2, 1101=digit 3, 1110=digit 4, 1111=blank
seg_n  input  7 [7:1]  segments, active-low: bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g
digit_1..digit_4  output  4 each  last decoded value per digit
digit_valid  output  4  bit k-1 set when digit_k holds a good capture
bad_pattern  output  4  bit k-1 set when the last capture of digit_k was an undecodable pattern
anode_error  output  1  one-cycle pulse: more than one enable low
order_error  output  1  one-cycle pulse: digit captured out of scan order
frame_done  output  1  one-cycle pulse: digits 1,2,3,4 captured in order

Behaviour:
- Reset, asynchronous, active-high. All outputs go to 0. Internal state after reset: input regs = 1111 / 1111111, stable count = 0, captured flag = 0, expected digit = 1, FSM in HUNT.
- Input stage: an_n and seg_n are registered once, into an_r and seg_r.
- Stable counter cnt, 4 bits:
  - If {an_n,seg_n} != {an_r,seg_r} at an edge: cnt <= 1 and the captured flag clears.
  - Otherwise cnt <= cnt+1, saturating at SETTLE_CYCLES.
- Capture strobe: cnt == SETTLE_CYCLES, captured flag = 0, and an_r is exactly one bit low. The strobe sets the captured flag, so there is one capture per dwell.
- Latency: when inputs change before edge E0 and then hold, outputs update at edge E0+SETTLE_CYCLES.
- Dwells shorter than SETTLE_CYCLES samples cause no capture.
- Decode table, seg_n[7:1] -> nibble:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F
- On capture of digit k:
  - Pattern in table: digit_k <= nibble, digit_valid[k-1] <= 1, bad_pattern[k-1] <= 0.
  - Pattern not in table: digit_k is held, digit_valid[k-1] <= 0, bad_pattern[k-1] <= 1.
- Blank dwell (an_r = 1111): no capture and no error. Order state is unchanged.
- Multi-enable dwell (two or more bits low), once stable for SETTLE_CYCLES:
  - anode_error pulses once per dwell.
  - FSM goes to HUNT and expected digit resets to 1.
  - Digit registers are untouched.
- Order FSM:
  - HUNT: a capture of digit 1 goes to SCAN with expected = 2. A capture of any other digit is silent; the FSM stays in HUNT.
  - SCAN: a capture of the expected digit advances expected. A capture of digit 4 when expected = 4 pulses frame_done on the same edge the digit registers update, then goes to HUNT.
  - SCAN: a capture of an unexpected digit pulses order_error. If that digit is 1, the FSM stays in SCAN with expected = 2; otherwise it goes to HUNT.
- A bad-pattern capture still counts for order tracking, but frame_done is suppressed if any bad_pattern bit is set at completion.
- Reset mid-dwell or mid-frame: state clears immediately. The next capture requires a full SETTLE_CYCLES of stable samples after reset deasserts.

Test Plan:
1. Reset: hold reset with inputs toggling. All outputs stay 0. After release with inputs held at an_n=0111, seg_n=0000110: digit_1=3 and digit_valid=0001 exactly 2 edges after the first sampling edge.
2. Decode sweep: on digit 2, apply each of the 16 table patterns for 4 cycles each. digit_2 steps 0..F and bad_pattern stays 0000.
3. Full scan: dwells of 8 cycles showing digits 1,2,3,4 = 1,2,3,4. Expect digit_1..4 = 1,2,3,4, digit_valid=1111, and exactly one frame_done pulse, coincident with the digit_4 update. Repeating the scan gives a second pulse.
4. Glitch: 1-cycle an_n=1011 blip between blanks. No output change; order_error = 0.
5. Errors:
   - seg_n=1111110 on digit 3: bad_pattern=0100, digit_3 held.
   - an_n=0011 for 4 cycles: anode_error pulses once, FSM returns to HUNT.
   - Scan 1,3: order_error pulses once.
6. Reset mid-frame: assert reset after digits 1 and 2 are captured. Outputs clear, and a subsequent 3,4 scan produces no frame_done.
